// File: rtl/ro_test_pkg.sv
// Shared definitions for ring-oscillator test blocks: sequencer state encoding,
// default widths and the Mode/Stress control pairs driven onto the oscillator.
package ro_test_pkg;

    localparam int RO_CNT_W  = 16;
    localparam int RO_TIME_W = 24;

    typedef logic [2:0] ro_seq_state_t;

    localparam ro_seq_state_t ST_IDLE    = 3'd0;
    localparam ro_seq_state_t ST_MEASURE = 3'd1;
    localparam ro_seq_state_t ST_REPORT  = 3'd2;
    localparam ro_seq_state_t ST_STRESS  = 3'd3;
    localparam ro_seq_state_t ST_SETTLE  = 3'd4;

    typedef struct packed {
        logic mode;
        logic stress;
    } ro_ctrl_t;

    localparam ro_ctrl_t CTRL_IDLE    = '{mode: 1'b0, stress: 1'b0};
    localparam ro_ctrl_t CTRL_MEASURE = '{mode: 1'b1, stress: 1'b0};
    localparam ro_ctrl_t CTRL_STRESS  = '{mode: 0, stress: 1'b1};

    // Only MEASURE and STRESS drive the oscillator; the two are mutually exclusive.
    function automatic ro_ctrl_t ctrl_for(input ro_seq_state_t st);
        ctrl_for = CTRL_IDLE;
        case (st)
            ST_MEASURE: ctrl_for = CTRL_MEASURE;
            ST_STRESS:  ctrl_for = CTRL_STRESS;
            default:    ctrl_for = CTRL_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/ro_edge_counter.sv
// Counts rising edges of an asynchronous oscillator output: 2-flop synchronizer,
// edge-detect flop and a saturating counter with synchronous clear and enable.
module ro_edge_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sig_in,
    input  logic             clear,
    input  logic             enable,
    output logic [CNT_W-1:0] count
);

    logic sync_q1;
    logic sync_q2;
    logic prev_q;
    logic rise;
    logic [CNT_W-1:0] count_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync_q1 <= sig_in;
            sync_q2 <= sync_q1;
            prev_q  <= sync_q2;
        end
    end

    assign rise = sync_q2 & ~prev_q;

    // Clear wins over counting; the count sticks at all-ones instead of wrapping.
    always_comb begin
        count_nxt = count;
        if (clear) begin
            count_nxt = '0;
        end else if (enable && rise && (count != '1)) begin
            count_nxt = count + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else begin
            count <= count_nxt;
        end
    end

endmodule

// File: rtl/ro_stress_sequencer.sv
// Ring-oscillator aging sequencer: baseline measurement, then n_iter rounds of
// DC stress, settle and measure, each count returned over a valid/ready handshake.
module ro_stress_sequencer
    import ro_test_pkg::*;
#(
    parameter int CNT_W         = RO_CNT_W,
    parameter int TIME_W        = RO_TIME_W,
    parameter int SETTLE_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [TIME_W-1:0] stress_len,
    input  logic [TIME_W-1:0] gate_len,
    input  logic [7:0]        n_iter,
    input  logic              ro_in,
    output logic              ro_mode,
    output logic              ro_stress,
    output logic              busy,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [CNT_W-1:0]  res_count,
    output logic [7:0]        res_index
);

    ro_seq_state_t     state;
    ro_seq_state_t     state_nxt;
    logic [TIME_W-1:0] dur;
    logic [TIME_W-1:0] dur_nxt;
    logic [TIME_W-1:0] stress_len_r;
    logic [TIME_W-1:0] gate_len_r;
    logic [7:0]        n_iter_r;
    logic              cnt_clear;
    logic              cnt_en;
    ro_ctrl_t          ctrl_nxt;

    // Each timed state loads its length on entry and leaves when one cycle remains.
    always_comb begin
        state_nxt = state;
        dur_nxt   = dur;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    if (gate_len == '0) begin
                        state_nxt = ST_REPORT;
                    end else begin
                        state_nxt = ST_MEASURE;
                        dur_nxt   = gate_len;
                    end
                end
            end
            ST_MEASURE: begin
                if (dur <= TIME_W'(1)) begin
                    state_nxt = ST_REPORT;
                    dur_nxt   = '0;
                end else begin
                    dur_nxt = dur - 1'b1;
                end
            end
            ST_REPORT: begin
                if (res_valid && res_ready) begin
                    if (res_index == n_iter_r) begin
                        state_nxt = ST_IDLE;
                    end else if (stress_len_r == '0) begin
                        state_nxt = ST_SETTLE;
                        dur_nxt   = TIME_W'(SETTLE_CYCLES);
                    end else begin
                        state_nxt = ST_STRESS;
                        dur_nxt   = stress_len_r;
                    end
                end
            end
            ST_STRESS: begin
                if (dur <= TIME_W'(1)) begin
                    state_nxt = ST_SETTLE;
                    dur_nxt   = TIME_W'(SETTLE_CYCLES);
                end else begin
                    dur_nxt = dur - 1'b1;
                end
            end
            ST_SETTLE: begin
                if (dur <= TIME_W'(1)) begin
                    if (gate_len_r == '0) begin
                        state_nxt = ST_REPORT;
                        dur_nxt   = '0;
                    end else begin
                        state_nxt = ST_MEASURE;
                        dur_nxt   = gate_len_r;
                    end
                end else begin
                    dur_nxt = dur - 1'b1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                dur_nxt   = '0;
            end
        endcase
        if (abort) begin
            state_nxt = ST_IDLE;
            dur_nxt   = '0;
        end
    end

    // A zero-length window reaches REPORT without MEASURE, so the count is cleared then too.
    assign cnt_clear = (state_nxt != state) &&
                       ((state_nxt == ST_MEASURE) ||
                        ((state_nxt == ST_REPORT) && (state != ST_MEASURE)));
    assign cnt_en    = (state == ST_MEASURE);
    assign ctrl_nxt  = ctrl_for(state_nxt);

    ro_edge_counter #(
        .CNT_W (CNT_W)
    ) u_edge_counter (
        .clk    (clk),
        .rst_n  (rst_n),
        .sig_in (ro_in),
        .clear  (cnt_clear),
        .enable (cnt_en),
        .count  (res_count)
    );

    // Outputs are decoded from the next state so they change together with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            dur          <= '0;
            stress_len_r <= '0;
            gate_len_r   <= '0;
            n_iter_r     <= '0;
            ro_mode      <= 1'b0;
            ro_stress    <= 1'b0;
            busy         <= 1'b0;
            res_valid    <= 1'b0;
            res_index    <= '0;
        end else begin
            state     <= state_nxt;
            dur       <= dur_nxt;
            ro_mode   <= ctrl_nxt.mode;
            ro_stress <= ctrl_nxt.stress;
            busy      <= (state_nxt != ST_IDLE);
            res_valid <= (state_nxt == ST_REPORT);
            if ((state == ST_IDLE) && start && !abort) begin
                stress_len_r <= stress_len;
                gate_len_r   <= gate_len;
                n_iter_r     <= n_iter;
                res_index    <= '0;
            end else if ((state == ST_REPORT) && (state_nxt != ST_IDLE) &&
                         (state_nxt != ST_REPORT)) begin
                res_index <= res_index + 1'b1;
            end
        end
    end

endmodule
